// File: rtl/vote_session.sv
// Three-judge majority vote session controller.
// Raw judge buttons are synchronized and debounced; accepted presses latch a vote
// during a bounded collection window, then a single-cycle verdict is produced.
// Optional feature: define VOTE_STATS_EN to keep saturating pass/fail session tallies.
module vote_session #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned WIN_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic       Y,
    output logic       VALID,
    output logic       BUSY,
    output logic [7:0] PASS_CNT,
    output logic [7:0] FAIL_CNT
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DECIDE  = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    // Count value at which the current cycle is the DB_CYCLES-th consecutive high cycle
    localparam logic [3:0] DB_LAST  = 4'(DB_CYCLES - 1);
    localparam logic [9:0] WIN_LAST = 10'(WIN_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0][3:0] db_cnt_q, db_cnt_d;
    logic [2:0]      accept;
    logic [2:0]      latch_q, latch_d;
    logic [9:0]      win_q, win_d;
    logic            y_q, y_d;

    // Two-flop synchronizer for the asynchronous judge buttons
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {C, B, A};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: counters only run in COLLECT, so a held press restarts at session entry
    always_comb begin
        accept   = '0;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (state_q == COLLECT && sync2_q[i]) begin
                if (db_cnt_q[i] >= DB_LAST) begin
                    accept[i]   = 1'b1;
                    db_cnt_d[i] = db_cnt_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Session FSM, vote latches, window counter and verdict next-state
    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        win_d   = win_q;
        y_d     = y_q;
        case (state_q)
            IDLE, HOLD: begin
                if (START) begin
                    state_d = COLLECT;
                    latch_d = '0;
                    win_d   = '0;
                    y_d     = 1'b0;
                end
            end
            COLLECT: begin
                latch_d = latch_q | accept;
                // Full vote set and window end on the same cycle still give one DECIDE
                if ((&latch_d) || (win_q == WIN_LAST)) begin
                    state_d = DECIDE;
                    y_d     = (latch_d[0] & latch_d[1]) | (latch_d[1] & latch_d[2]) |
                              (latch_d[0] & latch_d[2]);
                end else begin
                    win_d = win_q + 10'd1;
                end
            end
            DECIDE:  state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
            latch_q  <= '0;
            win_q    <= '0;
            y_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            latch_q  <= latch_d;
            win_q    <= win_d;
            y_q      <= y_d;
        end
    end

    assign Y     = y_q;
    assign VALID = (state_q == DECIDE);
    assign BUSY  = (state_q == COLLECT);

`ifdef VOTE_STATS_EN
    logic [7:0] pass_q, fail_q;

    // Saturating tallies, updated once per verdict
    always_ff @(posedge CLK) begin
        if (RST) begin
            pass_q <= '0;
            fail_q <= '0;
        end else if (state_q == DECIDE) begin
            if (y_q) begin
                if (pass_q != 8'hFF) pass_q <= pass_q + 8'd1;
            end else begin
                if (fail_q != 8'hFF) fail_q <= fail_q + 8'd1;
            end
        end
    end

    assign PASS_CNT = pass_q;
    assign FAIL_CNT = fail_q;
`else
    assign PASS_CNT = 8'd0;
    assign FAIL_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_vote_session.sv
// Self-checking bench for vote_session: a cycle-level behavioural model of the voting
// rules is compared against the DUT every cycle, plus directed scenarios with literal checks.
module tb_vote_session;

    localparam int DB  = 4;
    localparam int WIN = 1000;

`ifdef VOTE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0;
    logic       Y, VALID, BUSY;
    logic [7:0] PASS_CNT, FAIL_CNT;

    int tests = 0;
    int fails = 0;

    vote_session #(.DB_CYCLES(DB), .WIN_CYCLES(WIN)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .A       (A),
        .B       (B),
        .C       (C),
        .Y       (Y),
        .VALID   (VALID),
        .BUSY    (BUSY),
        .PASS_CNT(PASS_CNT),
        .FAIL_CNT(FAIL_CNT)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_live = 1'b0;
    bit [2:0] d0, d1, seen;     // two-sample delay seen by the judges' debouncers
    int       run   [3];        // consecutive high cycles inside the current session
    int       vote  [3];
    int       t;                // cycle index within the collection window
    int       nvotes;
    bit       collecting, verdict, m_y;
    int       m_pass, m_fail;

    task automatic model_step();
        if (RST) begin
            m_live = 1'b1;
            d0 = '0; d1 = '0;
            collecting = 1'b0; verdict = 1'b0; m_y = 1'b0;
            m_pass = 0; m_fail = 0; t = 0;
            for (int j = 0; j < 3; j++) begin run[j] = 0; vote[j] = 0; end
        end else begin
            seen = d1;
            d1 = d0;
            d0 = {C, B, A};
            if (collecting) begin
                nvotes = 0;
                for (int j = 0; j < 3; j++) begin
                    run[j] = seen[j] ? run[j] + 1 : 0;
                    if (run[j] >= DB) vote[j] = 1;
                    nvotes += vote[j];
                end
                if (nvotes == 3 || t == WIN - 1) begin
                    collecting = 1'b0;
                    verdict    = 1'b1;
                    m_y        = (nvotes >= 2);
                end else begin
                    t++;
                end
            end else if (verdict) begin
                verdict = 1'b0;
                if (STATS) begin
                    if (m_y) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
                    else     m_fail = (m_fail < 255) ? m_fail + 1 : 255;
                end
            end else if (START) begin
                collecting = 1'b1;
                t = 0;
                m_y = 1'b0;
                for (int j = 0; j < 3; j++) begin run[j] = 0; vote[j] = 0; end
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge CLK);
        if (m_live)
            check("cycle {Y,VALID,BUSY,PASS,FAIL}",
                  {13'd0, Y, VALID, BUSY, PASS_CNT, FAIL_CNT},
                  {13'd0, m_y, verdict, collecting, 8'(m_pass), 8'(m_fail)});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    // Pulse START; returns at the negedge of COLLECT cycle 0
    task automatic start_session();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Advance until VALID (bounded); optionally pulse START at COLLECT cycle poke_at
    task automatic wait_valid(input int k0, input int poke_at, output int k);
        k = k0;
        while (VALID !== 1'b1 && k < WIN + 100) begin
            tick();
            k++;
            START = (k == poke_at);
        end
        START = 1'b0;
    endtask

    task automatic release_all();
        A = 1'b0; B = 1'b0; C = 1'b0;
        repeat (4) tick();
    endtask

    // Drive A from a '0'/'1' pattern, one char per cycle starting at COLLECT cycle 1
    task automatic a_pattern(input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            tick();
            A = (pat[i] == "1");
        end
    endtask

    int k;

    initial begin
        // Reset for one edge, then check the reset state
        tick();
        RST = 1'b0;
        check("reset Y", Y, 0);
        check("reset VALID", VALID, 0);
        check("reset BUSY", BUSY, 0);
        check("reset PASS_CNT", PASS_CNT, 0);
        check("reset FAIL_CNT", FAIL_CNT, 0);

        // Two judges from cycle 2, third never: verdict at window end
        start_session();
        check("busy at collect entry", BUSY, 1);
        tick();
        A = 1'b1; B = 1'b1;
        wait_valid(1, -1, k);
        check("two-vote window end cycle", k, 1000);
        check("two-vote Y", Y, 1);
        tick();
        check("two-vote VALID single pulse", VALID, 0);
        check("two-vote Y held", Y, 1);
        check("two-vote PASS_CNT", PASS_CNT, STATS ? 1 : 0);
        release_all();

        // All three pressed at cycle 0: early decide after third acceptance
        start_session();
        A = 1'b1; B = 1'b1; C = 1'b1;
        wait_valid(0, -1, k);
        check("three-vote decide cycle", k, 6);
        check("three-vote Y", Y, 1);
        release_all();

        // Only C, with an ignored START mid-window: fail at window end
        start_session();
        C = 1'b1;
        wait_valid(0, 500, k);
        check("one-vote window end cycle", k, 1000);
        check("one-vote Y", Y, 0);
        tick();
        check("one-vote FAIL_CNT", FAIL_CNT, STATS ? 1 : 0);
        release_all();

        // Glitchy A never stable for four cycles: only B counts
        start_session();
        B = 1'b1;
        a_pattern("1110111001100000");
        wait_valid(16, -1, k);
        check("glitch window end cycle", k, 1000);
        check("glitch A rejected Y", Y, 0);
        release_all();

        // A held four cycles then released: vote kept
        start_session();
        B = 1'b1;
        a_pattern("1110111100000000");
        wait_valid(16, -1, k);
        check("held A window end cycle", k, 1000);
        check("held A accepted Y", Y, 1);
        release_all();

        // Reset mid-collect with two votes latched aborts the session
        start_session();
        A = 1'b1; B = 1'b1;
        repeat (10) tick();
        check("abort busy before reset", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort BUSY", BUSY, 0);
        check("abort VALID", VALID, 0);
        check("abort Y", Y, 0);
        check("abort PASS_CNT", PASS_CNT, 0);
        check("abort FAIL_CNT", FAIL_CNT, 0);
        repeat (20) tick();
        check("abort stays idle", BUSY, 0);
        release_all();

        // Presses held across start: debounce restarts at entry; 260 sessions saturate
        A = 1'b1; B = 1'b1; C = 1'b1;
        repeat (5) tick();
        for (int s = 0; s < 260; s++) begin
            start_session();
            wait_valid(0, -1, k);
            check("held-across-start decide cycle", k, 4);
            tick();
        end
        check("saturated PASS_CNT", PASS_CNT, STATS ? 255 : 0);
        check("saturated FAIL_CNT", FAIL_CNT, 0);
        release_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vote_session.md
VOTE_SESSION -- requirements
Module: vote_session

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, giving the consecutive stable cycles needed to accept a judge press (range 1..15).
REQ-002 The block SHALL have parameter WIN_CYCLES, default 1000, giving the vote window length in cycles (range 2..1023).
REQ-003 The block SHALL have one clock and synchronous active-high reset: ports CLK and RST.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 START  input  1  session start request, sampled high on a CLK edge.
REQ-007 A, B, C  input  1 each  raw judge buttons, asynchronous, active-high.
REQ-008 Y  output  1  registered majority verdict (1 = pass).
REQ-009 VALID  output  1  one-cycle pulse marking a new verdict on Y.
REQ-010 BUSY  output  1  high while a session is collecting votes.
REQ-011 PASS_CNT, FAIL_CNT  output  8 each  saturating session tallies.

Function
REQ-012 Each of A/B/C SHALL pass a 2-flop synchronizer, then a debounce counter; a vote is accepted when the synchronized level has been high for DB_CYCLES consecutive cycles.
REQ-013 FSM states SHALL be IDLE, COLLECT, DECIDE, HOLD.
REQ-014 IDLE or HOLD with START=1 -> COLLECT next cycle; the vote latches, window counter and Y clear to 0 on that transition.
REQ-015 In COLLECT each judge's vote latch SHALL set once on acceptance and stay set until the next session; releases are ignored.
REQ-016 COLLECT -> DECIDE when all three latches are set, or when the window counter reaches WIN_CYCLES-1, whichever comes first; both on the same cycle -> DECIDE once.
REQ-017 A judge not latched at window end SHALL count as a 0 vote.
REQ-018 In DECIDE (exactly one cycle) Y SHALL equal majority(LA,LB,LC) = LA·LB + LB·LC + LA·LC, VALID SHALL be 1, and then FSM -> HOLD.
REQ-019 Y SHALL hold its value through HOLD until the next session starts or RST.
REQ-020 START during COLLECT or DECIDE SHALL be ignored.
REQ-021 BUSY SHALL be 1 exactly in COLLECT.
REQ-022 Presses held across a session start SHALL still need DB_CYCLES stable cycles measured from debounce restart at COLLECT entry.

Reset
REQ-023 RST SHALL force state IDLE, Y=0, VALID=0, BUSY=0, PASS_CNT=0, FAIL_CNT=0, and clear synchronizers, debounce counters, vote latches and window counter.
REQ-024 RST asserted mid-COLLECT SHALL abort the session without a VALID pulse or tally update.

Configuration
REQ-025 Macro VOTE_STATS_EN: when defined, DECIDE SHALL increment PASS_CNT if Y=1 else FAIL_CNT, each saturating at 255.
REQ-026 Without VOTE_STATS_EN, PASS_CNT and FAIL_CNT SHALL be constant 0 and no tally registers SHALL exist.

Verification
REQ-027 RST 1 cycle, then START; hold A and B high from cycle 2 of COLLECT, C low -> Y=1, VALID single pulse at window end (no third vote), PASS_CNT=1.
REQ-028 START; A,B,C all pressed stable -> DECIDE in the cycle after the third acceptance (well before 1000 cycles), Y=1.
REQ-029 START; only C pressed; window expires at cycle 999 of COLLECT -> Y=0, VALID=1 at cycle 1000, FAIL_CNT=1.
REQ-030 A pulses high 3 cycles (DB_CYCLES=4) with glitches -> no acceptance; A held 4 cycles -> accepted; releasing A afterwards does not clear vote.
REQ-031 RST asserted during COLLECT with two votes latched -> no VALID, tallies unchanged, state IDLE, Y=0.
REQ-032 With VOTE_STATS_EN, run 260 passing sessions -> PASS_CNT saturates at 255; without macro both tallies read 0 throughout.
